posit_mul_issue: RTL and testbench
==================================

// Module: posit_mul_issue
// PURPOSE
//  Operand issue stage directly upstream of the combinational posit multiplier.
//  Buffers (A,B) operand pairs in a first-word-fall-through FIFO with valid/ready on both sides.
//  Pre-classifies each pair as NORMAL, ZERO or NaR so the datapath can bypass special cases.
//  Head-of-queue out_a/out_b drive the multiplier inputs IN1/IN2 directly.
// PARAMETERS
//  N      32  posit word width
//  ES     4   exponent field width; passed through to the shared package, unused in logic
//  DEPTH  4   FIFO entries; power of two, >= 2
//  CW     $clog2(DEPTH+1)  occupancy counter width; derived, do not override
// PORTS
//  clk           in   1      clock; all state updates on rising edge
//  reset         in   1      synchronous, active-high
//  flush         in   1      synchronous queue clear
//  in_valid      in   1      producer has an operand pair
//  in_ready      out  1      queue can accept a pair (= !full)
//  in_a          in   N      operand A (posit)
//  in_b          in   N      operand B (posit)
//  out_valid     out  1      head entry valid (= !empty)
//  out_ready     in   1      multiplier side consumes head
//  out_a         out  N      head operand A -> IN1
//  out_b         out  N      head operand B -> IN2
//  out_class     out  2      head class: posit_pkg::pclass_e
//  occupancy     out  CW     entries held, 0..DEPTH
//  ops_issued    out  32     issued-pair counter (stats)
//  specials_seen out  32     issued non-NORMAL counter (stats)
// BEHAVIOUR
//  - Reset: in_ready=1, out_valid=0, occupancy=0, out_a=out_b=0, out_class=NORMAL, ops_issued=specials_seen=0.
//  - Push = in_valid & in_ready. Pop = out_valid & out_ready. Both outputs come from registered state only; no ready->ready combinational path.
//  - Classification is computed at push and stored with the entry:
//    * NaR  = 1 followed by N-1 zeros.
//    * zero = all zeros.
//    * Class is NAR if either operand is NaR, else ZERO if either is zero, else NORMAL. NaR dominates (NaR x 0 = NaR).
//  - FWFT: the head is visible in the same cycle out_valid rises; latency from push to out_valid is 1 cycle.
//  - Empty: out_a, out_b and out_class hold their last values; consumers ignore them while out_valid=0.
//  - Full (occupancy==DEPTH): in_ready=0, so no push. A pop that cycle frees a slot; in_ready rises next cycle.
//  - Push and pop in the same cycle: occupancy is unchanged and both pointers advance. This is legal when full (push blocked) or empty (pop impossible) only as gated above.
//  - Pointers are log2(DEPTH) bits and wrap modulo DEPTH. Occupancy is a separate counter and distinguishes full from empty.
//  - flush: next cycle occupancy=0 and pointers=0. Any push or pop in the flush cycle is discarded, and counters do not increment. Stats are not cleared.
//  - reset overrides flush and everything else, including mid-burst; all queued data is lost.
//  - Data is never modified: out_a/out_b are bit-exact copies of in_a/in_b in FIFO order.
// CONFIGURATION
//  - POSIT_ISSUE_STATS_EN defined:
//    * ops_issued increments on every pop.
//    * specials_seen increments on every pop with class != NORMAL.
//    * Both saturate at 32'hFFFF_FFFF and are cleared only by reset.
//  - Not defined: both ports are tied to 0 and no counter flops are generated.
// STRUCTURE
//  - posit_pkg holds:
//    * typedef enum logic[1:0] {NORMAL=0, ZERO=1, NAR=2} pclass_e.
//    * functions is_zero(), is_nar() and classify_pair(), parameterised through N.
//  - Sub-module posit_pair_fifo: generic storage, pointers and occupancy for a {A, B, class} entry.
//  - The top level adds classification, flush gating and stats.
// TESTING  (N=32, DEPTH=4)
//  1. Reset, then push A=32'h4000_0000, B=32'h4000_0000 with out_ready=0
//     -> next cycle out_valid=1, out_class=NORMAL, occupancy=1.
//  2. Push 4 pairs with out_ready=0
//     -> in_ready=0 once occupancy=4; a 5th in_valid is not accepted.
//     Then hold out_ready=1 -> pairs drain in order; in_ready rises one cycle after the first pop.
//  3. Class check:
//     * A=32'h8000_0000, B=0 -> NAR.
//     * A=0, B=32'h3000_0000 -> ZERO.
//     * A=32'hC000_0000, B=32'h4000_0000 -> NORMAL (negative, not NaR).
//  4. Occupancy=2, then push+pop in the same cycle for 10 cycles -> occupancy stays 2; pointers wrap; order is preserved.
//  5. Occupancy=3 with in_valid=1 and flush=1 -> next cycle occupancy=0, out_valid=0; the flushed-cycle pair is absent.
//  6. With POSIT_ISSUE_STATS_EN: issue 5 pairs, 2 of them special -> ops_issued=5, specials_seen=2.
//     Without the macro, both ports read 0.

Source files
------------

// File: rtl/posit_pkg.sv
// Shared posit definitions: word geometry, operand class and special-value helpers.
package posit_pkg;

    localparam int unsigned N  = 32;
    localparam int unsigned ES = 4;

    typedef enum logic [1:0] {
        NORMAL = 2'd0,
        ZERO   = 2'd1,
        NAR    = 2'd2
    } pclass_e;

    function automatic logic is_zero(input logic [N-1:0] x);
        return x == '0;
    endfunction

    // NaR is the sign bit alone: 1 followed by N-1 zeros.
    function automatic logic is_nar(input logic [N-1:0] x);
        return x == {1'b1, {(N-1){1'b0}}};
    endfunction

    // NaR dominates zero, so NaR x 0 classifies as NaR.
    function automatic pclass_e classify_pair(input logic [N-1:0] a, input logic [N-1:0] b);
        if (is_nar(a) || is_nar(b)) begin
            return NAR;
        end
        if (is_zero(a) || is_zero(b)) begin
            return ZERO;
        end
        return NORMAL;
    endfunction

endpackage

// File: rtl/posit_mul_issue_if.sv
// Operand-issue bus: producer push side, multiplier pop side, flush and stats.
import posit_pkg::*;

interface posit_mul_issue_if #(
    parameter int unsigned N  = 32,
    parameter int unsigned CW = 3
);
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic [N-1:0]  in_a;
    logic [N-1:0]  in_b;
    logic          out_valid;
    logic          out_ready;
    logic [N-1:0]  out_a;
    logic [N-1:0]  out_b;
    pclass_e       out_class;
    logic [CW-1:0] occupancy;
    logic [31:0]   ops_issued;
    logic [31:0]   specials_seen;

    modport master (
        output flush, in_valid, in_a, in_b, out_ready,
        input  in_ready, out_valid, out_a, out_b, out_class, occupancy, ops_issued, specials_seen
    );

    modport slave (
        input  flush, in_valid, in_a, in_b, out_ready,
        output in_ready, out_valid, out_a, out_b, out_class, occupancy, ops_issued, specials_seen
    );
endinterface

// File: rtl/posit_pair_fifo.sv
// First-word-fall-through FIFO with a separate occupancy counter; the head holds its
// last popped value while empty.
module posit_pair_fifo #(
    parameter int unsigned W     = 66,
    parameter int unsigned DEPTH = 4,
    localparam int unsigned AW   = $clog2(DEPTH),
    localparam int unsigned CW   = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clr,
    input  logic          push,
    input  logic          pop,
    input  logic [W-1:0]  wdata,
    output logic [W-1:0]  rdata,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);
    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q;
    logic [W-1:0]  hold_q;
    logic          do_push, do_pop;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign do_push = push & ~full & ~clr;
    assign do_pop  = pop & ~empty & ~clr;
    assign rdata   = empty ? hold_q : mem_q[rd_ptr_q];

    // Storage write; contents need no reset because reads are gated by occupancy.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

    // Remember the departing head so the outputs keep their last value once empty.
    always_ff @(posedge clk) begin
        if (reset) begin
            hold_q <= '0;
        end else if ((pop || clr) && !empty) begin
            hold_q <= mem_q[rd_ptr_q];
        end
    end

    // Pointers wrap naturally (DEPTH is a power of two); occupancy tells full from empty.
    always_ff @(posedge clk) begin
        if (reset || clr) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            if (do_push && !do_pop) begin
                count_q <= count_q + 1'b1;
            end else if (do_pop && !do_push) begin
                count_q <= count_q - 1'b1;
            end
        end
    end

endmodule

// File: rtl/posit_mul_issue.sv
// Operand issue stage ahead of the posit multiplier: classifies pairs on entry, queues them,
// gates push/pop during flush and keeps issue statistics.
// Optional feature: define POSIT_ISSUE_STATS_EN to build the saturating stats counters.
import posit_pkg::*;

module posit_mul_issue #(
    parameter int unsigned N     = 32,
    parameter int unsigned ES    = 4,
    parameter int unsigned DEPTH = 4,
    localparam int unsigned CW   = $clog2(DEPTH + 1)
) (
    input logic              clk,
    input logic              reset,
    posit_mul_issue_if.slave bus
);
    localparam int unsigned W = 2 * N + 2;

    // Classification helpers are sized by the package word width.
    if (N != posit_pkg::N || ES >= N || DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_cfg
        $error("posit_mul_issue: unsupported N/ES/DEPTH combination");
    end

    logic          full, empty, push, pop;
    logic [W-1:0]  wdata, rdata;
    logic [CW-1:0] count;
    pclass_e       head_class;

    assign push       = bus.in_valid & ~full & ~bus.flush;
    assign pop        = ~empty & bus.out_ready & ~bus.flush;
    assign wdata      = {bus.in_a, bus.in_b, classify_pair(bus.in_a, bus.in_b)};
    assign head_class = pclass_e'(rdata[1:0]);

    posit_pair_fifo #(
        .W     (W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .clr   (bus.flush),
        .push  (push),
        .pop   (pop),
        .wdata (wdata),
        .rdata (rdata),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    assign bus.in_ready  = ~full;
    assign bus.out_valid = ~empty;
    assign bus.out_a     = rdata[W-1:N+2];
    assign bus.out_b     = rdata[N+1:2];
    assign bus.out_class = head_class;
    assign bus.occupancy = count;

`ifdef POSIT_ISSUE_STATS_EN
    logic [31:0] ops_q, specials_q;

    // Saturating issue counters; only reset clears them, flush does not.
    always_ff @(posedge clk) begin
        if (reset) begin
            ops_q      <= '0;
            specials_q <= '0;
        end else if (pop) begin
            if (ops_q != '1) begin
                ops_q <= ops_q + 32'd1;
            end
            if (head_class != NORMAL && specials_q != '1) begin
                specials_q <= specials_q + 32'd1;
            end
        end
    end

    assign bus.ops_issued    = ops_q;
    assign bus.specials_seen = specials_q;
`else
    assign bus.ops_issued    = '0;
    assign bus.specials_seen = '0;
`endif

endmodule

// File: tb/tb_posit_mul_issue.sv
// Self-checking bench for posit_mul_issue: directed scenarios plus random traffic,
// compared each cycle against a queue-based reference model.
module tb_posit_mul_issue;

    localparam int unsigned N     = 32;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned CW    = $clog2(DEPTH + 1);
    localparam logic [31:0] NAR_W = 32'h8000_0000;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [1:0]  c;
    } ent_t;

    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_fail   = 0;

    ent_t        mq[$];
    logic [31:0] exp_ops, exp_spec;

    always #5 clk = ~clk;

    posit_mul_issue_if #(.N(N), .CW(CW)) bus ();

    posit_mul_issue #(.N(N), .ES(4), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Class from the rules: any NaR operand wins, then any zero operand.
    function automatic logic [1:0] ref_class(input logic [31:0] a, input logic [31:0] b);
        if (a == NAR_W || b == NAR_W) return 2'd2;
        if (a == 32'd0 || b == 32'd0) return 2'd1;
        return 2'd0;
    endfunction

    function automatic logic [31:0] rnd_word();
        case ($urandom_range(0, 3))
            0:       return 32'd0;
            1:       return NAR_W;
            default: return $urandom();
        endcase
    endfunction

    // Check visible outputs against the model, clock once, then advance the model.
    task automatic step(input logic rst, input logic v, input logic [31:0] a, input logic [31:0] b,
                        input logic rdy, input logic fl);
        bit do_push, do_pop;
        ent_t e;
        reset         = rst;
        bus.in_valid  = v;
        bus.in_a      = a;
        bus.in_b      = b;
        bus.out_ready = rdy;
        bus.flush     = fl;
        #1;
        check_eq("in_ready", bus.in_ready, mq.size() < DEPTH);
        check_eq("out_valid", bus.out_valid, mq.size() > 0);
        check_eq("occupancy", bus.occupancy, mq.size());
        if (mq.size() > 0) begin
            check_eq("out_a", bus.out_a, mq[0].a);
            check_eq("out_b", bus.out_b, mq[0].b);
            check_eq("out_class", bus.out_class, mq[0].c);
        end
`ifdef POSIT_ISSUE_STATS_EN
        check_eq("ops_issued", bus.ops_issued, exp_ops);
        check_eq("specials_seen", bus.specials_seen, exp_spec);
`else
        check_eq("ops_issued_off", bus.ops_issued, 0);
        check_eq("specials_seen_off", bus.specials_seen, 0);
`endif
        do_push = v && (mq.size() < DEPTH);
        do_pop  = rdy && (mq.size() > 0);
        @(posedge clk);
        if (rst) begin
            mq.delete();
            exp_ops  = 0;
            exp_spec = 0;
        end else if (fl) begin
            mq.delete();
        end else begin
            if (do_pop) begin
                e = mq.pop_front();
                if (exp_ops != 32'hFFFF_FFFF) exp_ops++;
                if (e.c != 2'd0 && exp_spec != 32'hFFFF_FFFF) exp_spec++;
            end
            if (do_push) begin
                e.a = a;
                e.b = b;
                e.c = ref_class(a, b);
                mq.push_back(e);
            end
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        step(1'b1, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
        reset = 1'b0;
        #1;
        check_eq("rst_out_a", bus.out_a, 0);
        check_eq("rst_out_b", bus.out_b, 0);
        check_eq("rst_out_class", bus.out_class, 0);
        check_eq("rst_in_ready", bus.in_ready, 1);
    endtask

    task automatic push_pair(input logic [31:0] a, input logic [31:0] b, input logic rdy);
        step(1'b0, 1'b1, a, b, rdy, 1'b0);
    endtask

    task automatic drain();
        for (int i = 0; i < DEPTH + 1; i++) step(1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
    endtask

    initial begin
        reset         = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.out_ready = 1'b0;
        bus.flush     = 1'b0;
        exp_ops       = 0;
        exp_spec      = 0;
        @(negedge clk);
        do_reset();

        // 1: single push, head visible next cycle
        push_pair(32'h4000_0000, 32'h4000_0000, 1'b0);
        check_eq("t1_valid", bus.out_valid, 1);
        check_eq("t1_class", bus.out_class, 0);
        check_eq("t1_occ", bus.occupancy, 1);

        // 2: fill to DEPTH, 5th push refused, then drain in order
        for (int i = 0; i < 4; i++) push_pair(32'h1000_0000 + i, 32'h2000_0000 + i, 1'b0);
        check_eq("t2_full_ready", bus.in_ready, 0);
        check_eq("t2_full_occ", bus.occupancy, DEPTH);
        drain();

        // 3: classification cases
        push_pair(NAR_W, 32'd0, 1'b0);
        push_pair(32'd0, 32'h3000_0000, 1'b0);
        push_pair(32'hC000_0000, 32'h4000_0000, 1'b0);
        check_eq("t3_nar_head", bus.out_class, 2);
        drain();

        // 4: steady push+pop at occupancy 2 across pointer wrap
        push_pair(32'h1111_1111, 32'h2222_2222, 1'b0);
        push_pair(32'h3333_3333, 32'h4444_4444, 1'b0);
        for (int i = 0; i < 10; i++) push_pair($urandom(), $urandom(), 1'b1);
        check_eq("t4_occ", bus.occupancy, 2);
        drain();

        // 5: flush with a concurrent push discards everything
        for (int i = 0; i < 3; i++) push_pair(32'h5000_0000 + i, 32'h6000_0000, 1'b0);
        step(1'b0, 1'b1, 32'h7777_7777, 32'h7777_7777, 1'b1, 1'b1);
        check_eq("t5_occ", bus.occupancy, 0);
        check_eq("t5_valid", bus.out_valid, 0);
        push_pair(32'h0123_4567, 32'h89AB_CDEF, 1'b0);
        drain();

        // 6: stats over 5 issued pairs, 2 special
        do_reset();
        push_pair(32'h4000_0000, 32'h4000_0000, 1'b1);
        push_pair(NAR_W, 32'h4000_0000, 1'b1);
        push_pair(32'h5000_0000, 32'h4000_0000, 1'b1);
        push_pair(32'h4000_0000, 32'd0, 1'b1);
        push_pair(32'h6000_0000, 32'h7000_0000, 1'b1);
        drain();
`ifdef POSIT_ISSUE_STATS_EN
        check_eq("t6_ops", bus.ops_issued, 5);
        check_eq("t6_specials", bus.specials_seen, 2);
`else
        check_eq("t6_ops_off", bus.ops_issued, 0);
        check_eq("t6_specials_off", bus.specials_seen, 0);
`endif

        // Random traffic with occasional flush and reset
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 99) == 0, $urandom_range(0, 2) != 0, rnd_word(), rnd_word(),
                 $urandom_range(0, 2) != 0, $urandom_range(0, 19) == 0);
        end
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
